// File: rtl/vram_arbiter.sv
// vram_arbiter
// ------------
// Arbitrates a single-port framebuffer RAM between three masters with fixed
// priority: display scanout reads > host writes > frame-clear engine. At most
// one RAM access is issued per cycle. All mem_* outputs are registered.
//
// Handshake (host write channel): a transfer happens on every rising edge
// where host_valid and host_ready are both 1. host_ready is combinational,
// depends only on rst, disp_req and the FSM state (never on host_valid), and
// the accepted write is presented on the mem_* outputs in the next cycle.
// Out-of-range host writes (host_addr >= DEPTH) complete the handshake but
// are dropped and set the sticky oob_err flag until reset.
//
// Display reads: disp_req in cycle N -> RAM read in N+1 -> RAM data in N+2
// -> disp_valid/disp_data in N+3. Results come back in order, one per request.
//
// Build option: define VRAM_ARB_CLEAR_EN to compile in the frame-clear
// engine (IDLE/CLEAR FSM). Without it the clr_* inputs are ignored,
// clr_busy/clr_done stay 0 and the FSM never leaves IDLE.
//
// Ports
//   clk, rst                     pixel clock, synchronous active-high reset
//   disp_req, disp_addr          display read request and address
//   disp_valid, disp_data        returned pixel
//   host_valid/ready/addr/data   host write channel
//   clr_start, clr_color         start a frame clear with this colour
//   clr_busy, clr_done           clear in progress / one-cycle completion pulse
//   mem_en/we/addr/wdata, mem_rdata  single-port RAM, 1-cycle read latency
//   oob_err                      sticky out-of-range host address flag
//   state_o                      FSM state (0 = IDLE, 1 = CLEAR), for debug
module vram_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 921600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              oob_err,
    output logic              state_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rd_p2_q;
    logic                disp_valid_q;
    logic [DATA_W-1:0]   disp_data_q;
    logic                clr_done_q, clr_done_d;
    logic                oob_q, oob_d;
    logic                host_fire;
    logic                host_oob;

`ifdef VRAM_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0]   clr_color_q, clr_color_d;
`else
    logic unused_clr;
    assign unused_clr = ^{clr_start, clr_color};
`endif

    assign host_ready = ~rst & ~disp_req & (state_q == ST_IDLE);
    assign host_fire  = host_valid & host_ready;
    assign host_oob   = {1'b0, host_addr} >= DEPTH_L;

    always_comb begin
        state_d     = state_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        clr_done_d  = 1'b0;
        oob_d       = oob_q;
`ifdef VRAM_ARB_CLEAR_EN
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
`endif
        if (disp_req) begin
            mem_en_d   = 1'b1;
            mem_addr_d = disp_addr;
        end else if (host_fire) begin
            if (host_oob) begin
                oob_d = 1'b1;
            end else begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = host_addr;
                mem_wdata_d = host_data;
            end
        end
`ifdef VRAM_ARB_CLEAR_EN
        else if (state_q == ST_CLEAR) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = clr_addr_q;
            mem_wdata_d = clr_color_q;
            clr_addr_d  = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == LAST_ADDR) begin
                state_d    = ST_IDLE;
                clr_done_d = 1'b1;
            end
        end
        // Entry is independent of the host branch: a host write accepted on
        // the same edge is still issued next cycle, and the first clear write
        // is decided in the first CLEAR cycle, so the two never collide.
        if ((state_q == ST_IDLE) && clr_start) begin
            state_d     = ST_CLEAR;
            clr_addr_d  = '0;
            clr_color_d = clr_color;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_p2_q      <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            clr_done_q   <= 1'b0;
            oob_q        <= 1'b0;
`ifdef VRAM_ARB_CLEAR_EN
            clr_addr_q   <= '0;
            clr_color_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            // Read in flight on the RAM this cycle; its data arrives next cycle.
            rd_p2_q      <= mem_en_q & ~mem_we_q;
            disp_valid_q <= rd_p2_q;
            if (rd_p2_q) begin
                disp_data_q <= mem_rdata;
            end
            clr_done_q   <= clr_done_d;
            oob_q        <= oob_d;
`ifdef VRAM_ARB_CLEAR_EN
            clr_addr_q   <= clr_addr_d;
            clr_color_q  <= clr_color_d;
`endif
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign clr_busy   = (state_q == ST_CLEAR);
    assign clr_done   = clr_done_q;
    assign oob_err    = oob_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter. Directed scenarios, one task each, with a
// behavioural RAM (unwritten words read back as their own address) and a
// write log compared against an expected queue.
module tb_vram_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 24;
`ifdef VRAM_ARB_CLEAR_EN
    localparam int TB_DEPTH = 16;
`else
    localparam int TB_DEPTH = 921600;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              oob_err;
    logic              state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] wr_log[$];
    logic [DATA_W-1:0]        ram[int];

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(TB_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data),
        .clr_start(clr_start), .clr_color(clr_color),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .oob_err(oob_err), .state_o(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model + write log ----------------
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[int'(mem_addr)] = mem_wdata;
            wr_log.push_back({mem_addr, mem_wdata});
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : DATA_W'(mem_addr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver helpers ----------------
    task automatic idle_inputs();
        disp_req   = 1'b0;
        disp_addr  = '0;
        host_valid = 1'b0;
        host_addr  = '0;
        host_data  = '0;
        clr_start  = 1'b0;
        clr_color  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, disp_valid, clr_busy, clr_done, oob_err, host_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {mem_en, mem_we, disp_valid, clr_busy, clr_done, oob_err, host_ready});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, disp_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%0h wdata=%0h ddata=%0h expected all 0",
                     mem_addr, mem_wdata, disp_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_idle: got %b expected 1", host_ready);
        end
        disp_req = 1'b1;
        #1;
        n_cmp++;
        if (host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_disp_block: got %b expected 0", host_ready);
        end
        disp_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_disp_read();
        logic exp_en, exp_v;
        for (int k = 0; k < 8; k++) begin
            disp_req  = (k < 4);
            disp_addr = (k < 4) ? ADDR_W'(k) : '0;
            @(negedge clk);
            exp_en = (k >= 1 && k <= 4);
            exp_v  = (k >= 3 && k <= 6);
            n_cmp++;
            if (mem_en !== exp_en || (exp_en && (mem_we !== 1'b0 || mem_addr !== ADDR_W'(k - 1)))) begin
                n_fail++;
                $display("FAIL disp_issue k=%0d: got en=%b we=%b addr=%0h expected en=%b we=0 addr=%0h",
                         k, mem_en, mem_we, mem_addr, exp_en, k - 1);
            end
            n_cmp++;
            if (disp_valid !== exp_v || (exp_v && disp_data !== DATA_W'(k - 3))) begin
                n_fail++;
                $display("FAIL disp_return k=%0d: got v=%b d=%0h expected v=%b d=%0h",
                         k, disp_valid, disp_data, exp_v, k - 3);
            end
            next_cycle();
        end
    endtask

    task automatic test_host_write();
        disp_req   = 1'b1;
        disp_addr  = ADDR_W'(9);
        host_valid = 1'b1;
        host_addr  = ADDR_W'(5);
        host_data  = 24'h00B4FF;
        #1;
        n_cmp++;
        if (host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL host_blocked: got ready=%b expected 0", host_ready);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we} !== 2'b10 || mem_addr !== ADDR_W'(9)) begin
            n_fail++;
            $display("FAIL host_blocked_access: got en=%b we=%b addr=%0h expected en=1 we=0 addr=9",
                     mem_en, mem_we, mem_addr);
        end
        next_cycle();
        disp_req = 1'b0;
        #1;
        n_cmp++;
        if (host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL host_ready_after_drop: got %b expected 1", host_ready);
        end
        next_cycle();
        host_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== ADDR_W'(5) || mem_wdata !== 24'h00B4FF) begin
            n_fail++;
            $display("FAIL host_write_issue: got en=%b we=%b addr=%0h wdata=%0h expected 1 1 5 00b4ff",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (mem_en !== 1'b0 || oob_err !== 1'b0) begin
            n_fail++;
            $display("FAIL host_write_single: got en=%b oob=%b expected en=0 oob=0", mem_en, oob_err);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] rd_exp[4];
        exp_q.delete();
        wr_log.delete();
        for (int k = 0; k < 4; k++) begin
            host_valid = (k < 3);
            host_addr  = ADDR_W'(10 + k);
            host_data  = 24'hA00000 + DATA_W'(k * 24'h111);
            if (k < 3) exp_q.push_back({ADDR_W'(10 + k), 24'hA00000 + DATA_W'(k * 24'h111)});
            @(negedge clk);
            if (k >= 1) begin
                n_cmp++;
                if ({mem_en, mem_we} !== 2'b11 || mem_addr !== ADDR_W'(9 + k)) begin
                    n_fail++;
                    $display("FAIL b2b_issue k=%0d: got en=%b we=%b addr=%0h expected 1 1 %0h",
                             k, mem_en, mem_we, mem_addr, 9 + k);
                end
            end
            next_cycle();
        end
        next_cycle();
        n_cmp++;
        if (wr_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected %0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (wr_log[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_write[%0d]: got %0h expected %0h", i, wr_log[i], exp_q[i]);
                end
            end
        end
        // Read everything back through the display port, back to back.
        rd_exp = '{24'hA00000, 24'hA00111, 24'hA00222, 24'h00B4FF};
        for (int k = 0; k < 8; k++) begin
            disp_req  = (k < 4);
            disp_addr = (k == 3) ? ADDR_W'(5) : ADDR_W'(10 + k);
            @(negedge clk);
            if (k >= 3 && k <= 6) begin
                n_cmp++;
                if (disp_valid !== 1'b1 || disp_data !== rd_exp[k - 3]) begin
                    n_fail++;
                    $display("FAIL readback k=%0d: got v=%b d=%0h expected v=1 d=%0h",
                             k, disp_valid, disp_data, rd_exp[k - 3]);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_oob();
        host_valid = 1'b1;
        host_addr  = ADDR_W'(TB_DEPTH);
        host_data  = 24'h00DEAD;
        #1;
        n_cmp++;
        if (host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_ready: got %b expected 1", host_ready);
        end
        next_cycle();
        host_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_en !== 1'b0 || oob_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_drop: got en=%b oob=%b expected en=0 oob=1", mem_en, oob_err);
        end
        next_cycle();
        host_valid = 1'b1;
        host_addr  = ADDR_W'(TB_DEPTH - 1);
        host_data  = 24'h0F0F0F;
        next_cycle();
        host_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== ADDR_W'(TB_DEPTH - 1) || mem_wdata !== 24'h0F0F0F) begin
            n_fail++;
            $display("FAIL last_addr_write: got en=%b we=%b addr=%0h wdata=%0h expected 1 1 %0h 0f0f0f",
                     mem_en, mem_we, mem_addr, mem_wdata, TB_DEPTH - 1);
        end
        for (int k = 0; k < 5; k++) next_cycle();
        @(negedge clk);
        n_cmp++;
        if (oob_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_sticky: got %b expected 1", oob_err);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (oob_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_reset: got %b expected 0", oob_err);
        end
        next_cycle();
    endtask

`ifdef VRAM_ARB_CLEAR_EN
    task automatic test_clear();
        logic exp_busy, exp_done, exp_ready;
        exp_q.delete();
        wr_log.delete();
        for (int i = 0; i < TB_DEPTH; i++) exp_q.push_back({ADDR_W'(i), 24'h123456});
        for (int c = 0; c < 23; c++) begin
            clr_start = (c == 0 || c == 10);
            clr_color = (c == 0) ? 24'h123456 : 24'h654321;
            disp_req  = (c >= 5 && c <= 7);
            disp_addr = ADDR_W'(c);
            exp_busy  = (c >= 1 && c <= 19);
            exp_done  = (c == 20);
            exp_ready = !exp_busy && !disp_req;
            #1;
            n_cmp++;
            if (host_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL clear_ready c=%0d: got %b expected %b", c, host_ready, exp_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (clr_busy !== exp_busy || clr_done !== exp_done) begin
                n_fail++;
                $display("FAIL clear_status c=%0d: got busy=%b done=%b expected busy=%b done=%b",
                         c, clr_busy, clr_done, exp_busy, exp_done);
            end
            next_cycle();
        end
        idle_inputs();
        n_cmp++;
        if (wr_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL clear_count: got %0d expected %0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (wr_log[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL clear_write[%0d]: got %0h expected %0h", i, wr_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_clear_host_same_edge();
        logic exp_busy, exp_done;
        exp_q.delete();
        wr_log.delete();
        exp_q.push_back({ADDR_W'(3), 24'hAAAAAA});
        for (int i = 0; i < TB_DEPTH; i++) exp_q.push_back({ADDR_W'(i), 24'h0000FF});
        for (int c = 0; c < 20; c++) begin
            host_valid = (c == 0);
            host_addr  = ADDR_W'(3);
            host_data  = 24'hAAAAAA;
            clr_start  = (c == 0);
            clr_color  = 24'h0000FF;
            exp_busy   = (c >= 1 && c <= 16);
            exp_done   = (c == 17);
            @(negedge clk);
            n_cmp++;
            if (clr_busy !== exp_busy || clr_done !== exp_done) begin
                n_fail++;
                $display("FAIL same_edge_status c=%0d: got busy=%b done=%b expected busy=%b done=%b",
                         c, clr_busy, clr_done, exp_busy, exp_done);
            end
            next_cycle();
        end
        idle_inputs();
        n_cmp++;
        if (wr_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL same_edge_count: got %0d expected %0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (wr_log[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL same_edge_write[%0d]: got %0h expected %0h", i, wr_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_clear_abort();
        exp_q.delete();
        wr_log.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back({ADDR_W'(i), 24'h777777});
        for (int c = 0; c < 17; c++) begin
            clr_start = (c == 0);
            clr_color = 24'h777777;
            disp_req  = (c == 8);
            disp_addr = ADDR_W'(2);
            rst       = (c == 9);
            #1;
            if (c == 9) begin
                n_cmp++;
                if (host_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_ready_in_reset: got %b expected 0", host_ready);
                end
            end
            @(negedge clk);
            if (c == 9) begin
                n_cmp++;
                if (clr_busy !== 1'b1 || {mem_en, mem_we} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL abort_pre: got busy=%b en=%b we=%b expected busy=1 en=1 we=0",
                             clr_busy, mem_en, mem_we);
                end
            end
            if (c == 10) begin
                n_cmp++;
                if ({mem_en, mem_we, disp_valid, clr_busy, clr_done, oob_err} !== 6'b0 ||
                    {mem_addr, mem_wdata, disp_data} !== '0) begin
                    n_fail++;
                    $display("FAIL abort_reset_vals: got en=%b we=%b v=%b busy=%b done=%b oob=%b addr=%0h wd=%0h dd=%0h expected all 0",
                             mem_en, mem_we, disp_valid, clr_busy, clr_done, oob_err, mem_addr, mem_wdata, disp_data);
                end
            end
            if (c >= 10) begin
                n_cmp++;
                if (clr_done !== 1'b0 || disp_valid !== 1'b0 || clr_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_quiet c=%0d: got done=%b v=%b busy=%b expected 0 0 0",
                             c, clr_done, disp_valid, clr_busy);
                end
            end
            next_cycle();
        end
        idle_inputs();
        rst = 1'b0;
        n_cmp++;
        if (wr_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL abort_count: got %0d expected %0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (wr_log[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL abort_write[%0d]: got %0h expected %0h", i, wr_log[i], exp_q[i]);
                end
            end
        end
    endtask
`else
    task automatic test_clear_disabled();
        for (int c = 0; c < 6; c++) begin
            clr_start = (c == 0 || c == 2);
            clr_color = 24'h123456;
            #1;
            n_cmp++;
            if (host_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL nodis_ready c=%0d: got %b expected 1", c, host_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (clr_busy !== 1'b0 || clr_done !== 1'b0 || mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL nodis_status c=%0d: got busy=%b done=%b en=%b expected 0 0 0",
                         c, clr_busy, clr_done, mem_en);
            end
            next_cycle();
        end
        idle_inputs();
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_disp_read();
        test_host_write();
        test_back_to_back();
        test_oob();
`ifdef VRAM_ARB_CLEAR_EN
        test_clear();
        test_clear_host_same_edge();
        test_clear_abort();
`else
        test_clear_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
